// File: rtl/rv32imf_pkg.sv
// ---------------------------------------------------------------------------
// rv32imf_pkg
// Shared constants and types for the RV32IMF core slice. This file holds the
// platform interrupt controller register map and the gateway state type.
// ---------------------------------------------------------------------------
package rv32imf_pkg;

  // PLIC register word addresses (6-bit register port)
  localparam logic [5:0] PLIC_ADDR_PRIO_BASE = 6'h00;  // 0x00-0x1F priority[id]
  localparam logic [5:0] PLIC_ADDR_ENABLE    = 6'h20;
  localparam logic [5:0] PLIC_ADDR_THRESH    = 6'h21;
  localparam logic [5:0] PLIC_ADDR_PENDING   = 6'h22;
  localparam logic [5:0] PLIC_ADDR_EDGE      = 6'h23;

  // Per-source gateway state
  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_PEND    = 2'd1,
    GW_CLAIMED = 2'd2
  } plic_gw_state_e;

endpackage

// File: rtl/rv32imf_plic_gateway.sv
// ---------------------------------------------------------------------------
// rv32imf_plic_gateway
// One interrupt gateway: IDLE -> PEND -> CLAIMED -> IDLE.
// Optional feature macro: RV32IMF_PLIC_EDGE_EN adds rising-edge detection and
// a 1-deep edge latch that re-pends the gateway directly on complete.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   src         raw source level (synchronous to clk)
//   claim       this source is being claimed (claim pulse and best ID match)
//   complete    completion addressed to this source
//   edge_mode   (edge build only) 1 = rising-edge triggered
//   pending     1 while the gateway is in PEND
// ---------------------------------------------------------------------------
module rv32imf_plic_gateway
  import rv32imf_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  input  logic claim,
  input  logic complete,
`ifdef RV32IMF_PLIC_EDGE_EN
  input  logic edge_mode,
`endif
  output logic pending
);

  plic_gw_state_e state_r;
  plic_gw_state_e state_nxt_s;
  logic           trig_s;

`ifdef RV32IMF_PLIC_EDGE_EN
  logic src_prev_r;
  logic latch_r;
  logic latch_nxt_s;

  assign trig_s = edge_mode ? (src & ~src_prev_r) : src;
`else
  assign trig_s = src;
`endif

  // Next-state logic for the gateway FSM (and the edge latch when built).
  always_comb begin
    state_nxt_s = state_r;
`ifdef RV32IMF_PLIC_EDGE_EN
    latch_nxt_s = latch_r;
`endif
    case (state_r)
      GW_IDLE: begin
        if (trig_s) state_nxt_s = GW_PEND;
        else        state_nxt_s = GW_IDLE;
      end
      GW_PEND: begin
        if (claim) state_nxt_s = GW_CLAIMED;
        else       state_nxt_s = GW_PEND;
`ifdef RV32IMF_PLIC_EDGE_EN
        // an edge while already pending is remembered for after completion
        if (edge_mode && trig_s) latch_nxt_s = 1'b1;
        else                     latch_nxt_s = latch_r;
`endif
      end
      GW_CLAIMED: begin
`ifdef RV32IMF_PLIC_EDGE_EN
        if (complete) begin
          // a latched edge (or one arriving now) skips IDLE entirely
          if (latch_r || (edge_mode && trig_s)) state_nxt_s = GW_PEND;
          else                                  state_nxt_s = GW_IDLE;
          latch_nxt_s = 1'b0;
        end else begin
          state_nxt_s = GW_CLAIMED;
          if (edge_mode && trig_s) latch_nxt_s = 1'b1;
          else                     latch_nxt_s = latch_r;
        end
`else
        if (complete) state_nxt_s = GW_IDLE;
        else          state_nxt_s = GW_CLAIMED;
`endif
      end
      default: begin
        state_nxt_s = GW_IDLE;
`ifdef RV32IMF_PLIC_EDGE_EN
        latch_nxt_s = 1'b0;
`endif
      end
    endcase
  end

  // Gateway state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= GW_IDLE;
`ifdef RV32IMF_PLIC_EDGE_EN
      src_prev_r <= 1'b0;
      latch_r    <= 1'b0;
`endif
    end else begin
      state_r    <= state_nxt_s;
`ifdef RV32IMF_PLIC_EDGE_EN
      src_prev_r <= src;
      latch_r    <= latch_nxt_s;
`endif
    end
  end

  assign pending = (state_r == GW_PEND);

endmodule

// File: rtl/rv32imf_plic_lite.sv
// ---------------------------------------------------------------------------
// rv32imf_plic_lite
// Platform-level interrupt arbiter producing the machine external interrupt.
// Holds the priority/enable/threshold registers, one gateway per source, a
// linear-scan priority arbiter and the registered winner best_id_q.
// Optional feature macro: RV32IMF_PLIC_EDGE_EN (per-source edge mode, reg 0x23).
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   src_i          raw sources, ID k = src_i[k-1]
//   cfg_we_i/cfg_addr_i/cfg_wdata_i/cfg_rdata_o  single-cycle register port
//                  (read data is combinational from cfg_addr_i)
//   claim_i        claim pulse; claim_id_o returns best_id_q in the same cycle
//   complete_i/complete_id_i  completion pulse and ID
//   meip_o         external interrupt pending = (best_id_q != 0)
// ---------------------------------------------------------------------------
module rv32imf_plic_lite
  import rv32imf_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic               cfg_we_i,
  input  logic [5:0]         cfg_addr_i,
  input  logic [31:0]        cfg_wdata_i,
  output logic [31:0]        cfg_rdata_o,
  input  logic               claim_i,
  output logic [4:0]         claim_id_o,
  input  logic               complete_i,
  input  logic [4:0]         complete_id_i,
  output logic               meip_o
);

  logic [PRIO_W-1:0] prio_r [1:NUM_SRC];
  logic [NUM_SRC:1]  enable_r;
  logic [PRIO_W-1:0] thresh_r;
  logic [NUM_SRC:1]  pending_s;
  logic [4:0]        best_id_q;
  logic [4:0]        best_id_s;
  logic [PRIO_W-1:0] best_prio_s;
  logic [31:0]       rdata_s;
  logic              wdata_unused_s;
`ifdef RV32IMF_PLIC_EDGE_EN
  logic [NUM_SRC:1]  edge_r;
`endif

  assign wdata_unused_s = ^cfg_wdata_i;

  // Configuration register writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 1; k <= NUM_SRC; k++) prio_r[k] <= {PRIO_W{1'b0}};
      enable_r <= {NUM_SRC{1'b0}};
      thresh_r <= {PRIO_W{1'b0}};
`ifdef RV32IMF_PLIC_EDGE_EN
      edge_r   <= {NUM_SRC{1'b0}};
`endif
    end else if (cfg_we_i) begin
      for (int k = 1; k <= NUM_SRC; k++) begin
        if (cfg_addr_i == PLIC_ADDR_PRIO_BASE + 6'(k)) prio_r[k] <= cfg_wdata_i[PRIO_W-1:0];
      end
      case (cfg_addr_i)
        PLIC_ADDR_ENABLE: enable_r <= cfg_wdata_i[NUM_SRC:1];
        PLIC_ADDR_THRESH: thresh_r <= cfg_wdata_i[PRIO_W-1:0];
`ifdef RV32IMF_PLIC_EDGE_EN
        PLIC_ADDR_EDGE:   edge_r   <= cfg_wdata_i[NUM_SRC:1];
`endif
        default: ;
      endcase
    end
  end

  // One gateway per source; ID 0 never matches a claim or complete.
  for (genvar g = 1; g <= NUM_SRC; g++) begin : g_gw
    rv32imf_plic_gateway u_gw (
      .clk      (clk),
      .rst_n    (rst_n),
      .src      (src_i[g-1]),
      .claim    (claim_i && (best_id_q == 5'(g))),
      .complete (complete_i && (complete_id_i == 5'(g))),
`ifdef RV32IMF_PLIC_EDGE_EN
      .edge_mode(edge_r[g]),
`endif
      .pending  (pending_s[g])
    );
  end

  // Linear-scan arbiter: strict '>' keeps the lowest ID on priority ties.
  always_comb begin
    best_id_s   = 5'd0;
    best_prio_s = {PRIO_W{1'b0}};
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (pending_s[k] && enable_r[k] && (prio_r[k] > thresh_r) && (prio_r[k] > best_prio_s)) begin
        best_id_s   = 5'(k);
        best_prio_s = prio_r[k];
      end else begin
        best_prio_s = best_prio_s;
      end
    end
  end

  // Registered arbitration result.
  always_ff @(posedge clk) begin
    if (!rst_n) best_id_q <= 5'd0;
    else        best_id_q <= best_id_s;
  end

  // Combinational read mux.
  always_comb begin
    rdata_s = 32'd0;
    case (cfg_addr_i)
      PLIC_ADDR_ENABLE:  rdata_s[NUM_SRC:1]  = enable_r;
      PLIC_ADDR_THRESH:  rdata_s[PRIO_W-1:0] = thresh_r;
      PLIC_ADDR_PENDING: rdata_s[NUM_SRC:1]  = pending_s;
`ifdef RV32IMF_PLIC_EDGE_EN
      PLIC_ADDR_EDGE:    rdata_s[NUM_SRC:1]  = edge_r;
`endif
      default: begin
        for (int k = 1; k <= NUM_SRC; k++) begin
          if (cfg_addr_i == PLIC_ADDR_PRIO_BASE + 6'(k)) rdata_s[PRIO_W-1:0] = prio_r[k];
          else                                            rdata_s = rdata_s;
        end
      end
    endcase
  end

  assign cfg_rdata_o = rdata_s;
  assign claim_id_o  = best_id_q;
  assign meip_o      = (best_id_q != 5'd0);

endmodule
